// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, address+R/W, ACK slot, one data byte, STOP.
// Optional feature macro: I2C_ACK_CHECK_EN (evaluate ACK slots, report o_nack).
module i2c_master_byte #(
   parameter int SYS_CLK_HZ = 100_000_000,
   parameter int I2C_HZ     = 100_000
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic       i_valid,
   input  logic [6:0] i_addr,
   input  logic [7:0] i_data,
   input  logic       i_RW,
   output logic       o_busy,
   output logic [7:0] o_receive,
   output logic       o_nack,
   output logic       scl,
   inout  wire        sda
);

   localparam int QTR = SYS_CLK_HZ / (4 * I2C_HZ);
   localparam int CW  = (QTR > 1) ? $clog2(QTR) : 1;
   localparam logic [CW-1:0] QTR_LAST = CW'(QTR - 1);

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_NACK, STOP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] qtrCnt_q, qtrCnt_d;
   logic [1:0]    quarter_q, quarter_d;
   logic [2:0]    bitCnt_q, bitCnt_d;
   logic [7:0]    addrRw_q, addrRw_d;
   logic [7:0]    data_q, data_d;
   logic [7:0]    rx_q, rx_d;
   logic [7:0]    receive_q, receive_d;
`ifdef I2C_ACK_CHECK_EN
   logic          nack_q, nack_d;
`endif

   logic tick;
   logic bitEnd;
   logic samplePt;
   logic dataScl;
   logic sclOut;
   logic sdaLow;

   assign tick     = (qtrCnt_q == QTR_LAST);
   assign bitEnd   = tick && (quarter_q == 2'd3);
   assign samplePt = (quarter_q == 2'd2) && (qtrCnt_q == '0);
   assign dataScl  = (quarter_q == 2'd1) || (quarter_q == 2'd2);

   always_comb begin
      state_d   = state_q;
      addrRw_d  = addrRw_q;
      data_d    = data_q;
      rx_d      = rx_q;
      receive_d = receive_q;
`ifdef I2C_ACK_CHECK_EN
      nack_d    = nack_q;
`endif
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               state_d  = START;
               addrRw_d = {i_addr, i_RW};
               data_d   = i_data;
`ifdef I2C_ACK_CHECK_EN
               nack_d   = 1'b0;
`endif
            end
         end
         START: begin
            if (bitEnd) state_d = ADDR;
         end
         ADDR: begin
            if (bitEnd && (bitCnt_q == 3'd7)) state_d = ADDR_ACK;
         end
         ADDR_ACK: begin
`ifdef I2C_ACK_CHECK_EN
            if (samplePt && sda) nack_d = 1'b1;
`endif
            if (bitEnd) begin
               state_d = addrRw_q[0] ? READ : WRITE;
`ifdef I2C_ACK_CHECK_EN
               // An unanswered address skips the data byte entirely.
               if (nack_q) state_d = STOP;
`endif
            end
         end
         WRITE: begin
            if (bitEnd && (bitCnt_q == 3'd7)) state_d = WRITE_ACK;
         end
         WRITE_ACK: begin
`ifdef I2C_ACK_CHECK_EN
            if (samplePt && sda) nack_d = 1'b1;
`endif
            if (bitEnd) state_d = STOP;
         end
         READ: begin
            if (samplePt) rx_d = {rx_q[6:0], sda};
            if (bitEnd && (bitCnt_q == 3'd7)) state_d = READ_NACK;
         end
         READ_NACK: begin
            if (bitEnd) begin
               receive_d = rx_q;
               state_d   = STOP;
            end
         end
         STOP: begin
            if (bitEnd) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Bit counter restarts whenever the state changes so single-bit states never leak a count.
   always_comb begin
      qtrCnt_d  = qtrCnt_q;
      quarter_d = quarter_q;
      bitCnt_d  = bitCnt_q;
      if (state_q == IDLE) begin
         qtrCnt_d  = '0;
         quarter_d = 2'd0;
         bitCnt_d  = 3'd0;
      end else if (tick) begin
         qtrCnt_d  = '0;
         quarter_d = quarter_q + 2'd1;
         if (bitEnd) bitCnt_d = (state_d != state_q) ? 3'd0 : bitCnt_q + 3'd1;
      end else begin
         qtrCnt_d = qtrCnt_q + CW'(1);
      end
   end

   always_comb begin
      sclOut = 1'b1;
      sdaLow = 1'b0;
      case (state_q)
         START: begin
            sdaLow = quarter_q[1];
            sclOut = (quarter_q != 2'd3);
         end
         ADDR: begin
            sclOut = dataScl;
            sdaLow = ~addrRw_q[3'd7 - bitCnt_q];
         end
         WRITE: begin
            sclOut = dataScl;
            sdaLow = ~data_q[3'd7 - bitCnt_q];
         end
         ADDR_ACK, WRITE_ACK, READ, READ_NACK: begin
            sclOut = dataScl;
         end
         STOP: begin
            sclOut = (quarter_q != 2'd0);
            sdaLow = ~quarter_q[1];
         end
         default: begin
            sclOut = 1'b1;
            sdaLow = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_p) begin
         state_q   <= IDLE;
         qtrCnt_q  <= '0;
         quarter_q <= 2'd0;
         bitCnt_q  <= 3'd0;
         addrRw_q  <= 8'h00;
         data_q    <= 8'h00;
         rx_q      <= 8'h00;
         receive_q <= 8'h00;
`ifdef I2C_ACK_CHECK_EN
         nack_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         qtrCnt_q  <= qtrCnt_d;
         quarter_q <= quarter_d;
         bitCnt_q  <= bitCnt_d;
         addrRw_q  <= addrRw_d;
         data_q    <= data_d;
         rx_q      <= rx_d;
         receive_q <= receive_d;
`ifdef I2C_ACK_CHECK_EN
         nack_q    <= nack_d;
`endif
      end
   end

   assign o_busy    = (state_q != IDLE);
   assign o_receive = receive_q;
`ifdef I2C_ACK_CHECK_EN
   assign o_nack    = nack_q;
`else
   assign o_nack    = 1'b0;
`endif
   assign scl = sclOut;
   assign sda = sdaLow ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Directed bench for i2c_master_byte with a bus monitor and a simple PCF8574-like slave.
// Runs with QTR = 10 so a full transaction is 800 cycles.
module tb_i2c_master_byte;

   localparam int QTR      = 10;
   localparam int FULL_LEN = 80 * QTR;
   localparam int NACK_LEN = 44 * QTR;

   logic       clk = 1'b0;
   logic       reset_p = 1'b1;
   logic       i_valid = 1'b0;
   logic [6:0] i_addr = 7'h00;
   logic [7:0] i_data = 8'h00;
   logic       i_RW = 1'b0;
   logic       o_busy;
   logic [7:0] o_receive;
   logic       o_nack;
   logic       scl;
   wire        sda;

   int vecCnt = 0;
   int errCnt = 0;

   logic       slaveLow = 1'b0;
   logic       ackEnable = 1'b1;
   logic [7:0] readByte = 8'h00;

   logic capBits [0:19];
   int   riseCnt = 0;
   int   startCnt = 0;
   int   stopCnt = 0;
   int   fallCnt = 0;
   int   busyRun = 0;
   int   idleRun = 0;
   int   lastWidth = 0;
   int   lastGap = 0;
   logic [7:0] fallReceive = 8'h00;
   logic fallNack = 1'b0;
   logic sclPrev = 1'b1;
   logic sdaPrev = 1'b1;
   logic busyPrev = 1'b0;

   i2c_master_byte #(.SYS_CLK_HZ(4_000_000), .I2C_HZ(100_000)) dut (
      .clk       (clk),
      .reset_p   (reset_p),
      .i_valid   (i_valid),
      .i_addr    (i_addr),
      .i_data    (i_data),
      .i_RW      (i_RW),
      .o_busy    (o_busy),
      .o_receive (o_receive),
      .o_nack    (o_nack),
      .scl       (scl),
      .sda       (sda)
   );

   pullup (sda);
   assign sda = slaveLow ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   // Bus monitor and slave: decode START/STOP, capture bits on SCL rise, drive on SCL fall.
   always @(negedge clk) begin
      if (sclPrev && scl && sdaPrev && !sda) begin
         riseCnt  = 0;
         slaveLow = 1'b0;
         startCnt = startCnt + 1;
      end else if (sclPrev && scl && !sdaPrev && sda) begin
         stopCnt = stopCnt + 1;
      end
      if (!sclPrev && scl) begin
         if (riseCnt < 20) capBits[riseCnt] = sda;
         riseCnt = riseCnt + 1;
      end
      if (sclPrev && !scl) begin
         slaveLow = 1'b0;
         if (riseCnt == 8 || (riseCnt == 17 && !capBits[7]))
            slaveLow = ackEnable;
         else if (capBits[7] && riseCnt >= 9 && riseCnt <= 16)
            slaveLow = !readByte[16 - riseCnt];
      end
      if (o_busy && !busyPrev) begin
         lastGap = idleRun;
         busyRun = 0;
      end
      if (!o_busy && busyPrev) begin
         lastWidth   = busyRun;
         fallReceive = o_receive;
         fallNack    = o_nack;
         fallCnt     = fallCnt + 1;
         idleRun     = 0;
      end
      if (o_busy) busyRun = busyRun + 1;
      else        idleRun = idleRun + 1;
      sclPrev  = scl;
      sdaPrev  = sda;
      busyPrev = o_busy;
   end

   function automatic logic [7:0] capByte(input int base);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[7-i] = capBits[base+i];
      return b;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vecCnt = vecCnt + 1;
      if (actual !== expected) begin
         errCnt = errCnt + 1;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [6:0] a, input logic rw, input logic [7:0] d, input int hold);
      @(negedge clk);
      i_addr  = a;
      i_RW    = rw;
      i_data  = d;
      i_valid = 1'b1;
      @(negedge clk);
      checkOutput("busyRise", {31'd0, o_busy}, 32'd1);
      repeat (hold - 1) @(negedge clk);
      i_valid = 1'b0;
   endtask

   task automatic waitFall(input int target);
      int n;
      n = 0;
      while (fallCnt < target && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (fallCnt < target) checkOutput("busyFallTimeout", 32'd0, 32'd1);
   endtask

   initial begin
      int base;
      int sBase;
      int n;

      for (int i = 0; i < 20; i++) capBits[i] = 1'b1;
      repeat (3) @(negedge clk);
      reset_p = 1'b0;
      @(negedge clk);
      checkOutput("rstScl", {31'd0, scl}, 32'd1);
      checkOutput("rstSda", {31'd0, sda}, 32'd1);
      checkOutput("rstBusy", {31'd0, o_busy}, 32'd0);
      checkOutput("rstRecv", {24'd0, o_receive}, 32'h00);
      checkOutput("rstNack", {31'd0, o_nack}, 32'd0);

      // Write with slave ACKs
      $display("[TB] write 0x27 <- D9");
      base = fallCnt; sBase = stopCnt;
      applyStimulus(7'h27, 1'b0, 8'hD9, 1);
      waitFall(base + 1);
      checkOutput("wrAddr", {24'd0, capByte(0)}, 32'h4E);
      checkOutput("wrAck1", {31'd0, capBits[8]}, 32'd0);
      checkOutput("wrData", {24'd0, capByte(9)}, 32'hD9);
      checkOutput("wrAck2", {31'd0, capBits[17]}, 32'd0);
      checkOutput("wrWidth", lastWidth, FULL_LEN);
      checkOutput("wrRecv", {24'd0, fallReceive}, 32'h00);
      checkOutput("wrNack", {31'd0, fallNack}, 32'd0);
      checkOutput("wrStop", stopCnt - sBase, 32'd1);
      checkOutput("wrRises", riseCnt, 32'd19);

      // Read with slave returning A5
      $display("[TB] read 0x27 -> A5");
      readByte = 8'hA5;
      base = fallCnt;
      applyStimulus(7'h27, 1'b1, 8'h00, 1);
      waitFall(base + 1);
      checkOutput("rdAddr", {24'd0, capByte(0)}, 32'h4F);
      checkOutput("rdAck", {31'd0, capBits[8]}, 32'd0);
      checkOutput("rdData", {24'd0, capByte(9)}, 32'hA5);
      checkOutput("rdMasterNack", {31'd0, capBits[17]}, 32'd1);
      checkOutput("rdRecv", {24'd0, fallReceive}, 32'hA5);
      checkOutput("rdWidth", lastWidth, FULL_LEN);

      // No slave present
      $display("[TB] address with no slave");
      ackEnable = 1'b0;
      base = fallCnt;
      applyStimulus(7'h27, 1'b0, 8'h3C, 1);
      waitFall(base + 1);
`ifdef I2C_ACK_CHECK_EN
      checkOutput("nakWidth", lastWidth, NACK_LEN);
      checkOutput("nakFlag", {31'd0, fallNack}, 32'd1);
      checkOutput("nakRises", riseCnt, 32'd10);
`else
      checkOutput("nakWidth", lastWidth, FULL_LEN);
      checkOutput("nakFlag", {31'd0, fallNack}, 32'd0);
      checkOutput("nakRises", riseCnt, 32'd19);
`endif
      checkOutput("nakRecvHeld", {24'd0, fallReceive}, 32'hA5);
      ackEnable = 1'b1;

      // i_valid held 3 cycles, inputs changed while busy
      $display("[TB] busy handshake");
      base = fallCnt; sBase = startCnt;
      applyStimulus(7'h27, 1'b0, 8'h5A, 3);
      i_data = 8'hFF;
      i_addr = 7'h11;
      i_RW   = 1'b1;
      waitFall(base + 1);
      repeat (50) @(negedge clk);
      checkOutput("hsFalls", fallCnt - base, 32'd1);
      checkOutput("hsStarts", startCnt - sBase, 32'd1);
      checkOutput("hsAddr", {24'd0, capByte(0)}, 32'h4E);
      checkOutput("hsData", {24'd0, capByte(9)}, 32'h5A);

      // i_valid held high: back-to-back transactions
      $display("[TB] back-to-back");
      base = fallCnt; sBase = startCnt;
      @(negedge clk);
      i_addr = 7'h27; i_RW = 1'b0; i_data = 8'h81; i_valid = 1'b1;
      waitFall(base + 1);
      checkOutput("b2bWidth1", lastWidth, FULL_LEN);
      n = 0;
      while (!o_busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("b2bRestart", {31'd0, o_busy}, 32'd1);
      @(negedge clk);
      i_valid = 1'b0;
      checkOutput("b2bGap", {31'd0, (lastGap >= 1)}, 32'd1);
      waitFall(base + 2);
      checkOutput("b2bWidth2", lastWidth, FULL_LEN);
      checkOutput("b2bData", {24'd0, capByte(9)}, 32'h81);
      repeat (20) @(negedge clk);
      checkOutput("b2bStarts", startCnt - sBase, 32'd2);

      // Reset during address bit 3
      $display("[TB] reset mid-address");
      checkOutput("preRstRecv", {24'd0, o_receive}, 32'hA5);
      applyStimulus(7'h27, 1'b0, 8'hC3, 1);
      n = 0;
      while (riseCnt != 4 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("reachBit3", riseCnt, 32'd4);
      reset_p = 1'b1;
      @(negedge clk);
      checkOutput("midRstScl", {31'd0, scl}, 32'd1);
      checkOutput("midRstSda", {31'd0, sda}, 32'd1);
      checkOutput("midRstBusy", {31'd0, o_busy}, 32'd0);
      checkOutput("midRstRecv", {24'd0, o_receive}, 32'h00);
      reset_p = 1'b0;
      repeat (5) @(negedge clk);

      // Normal write after the abort
      $display("[TB] write after reset");
      base = fallCnt;
      applyStimulus(7'h27, 1'b0, 8'h42, 1);
      waitFall(base + 1);
      checkOutput("postAddr", {24'd0, capByte(0)}, 32'h4E);
      checkOutput("postData", {24'd0, capByte(9)}, 32'h42);
      checkOutput("postWidth", lastWidth, FULL_LEN);
      checkOutput("postNack", {31'd0, fallNack}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
      $finish;
   end

endmodule

// File: doc/i2c_master_byte.md
# i2c_master_byte

- Single-byte I2C master that sits between the CLCD command sequencers and the PCF8574 backpack (address 7'h27).
- On an `i_valid` request it runs one complete transaction: START, 7-bit address + R/W, ACK slot, one data byte, STOP.
- A write sends `i_data`. A read returns the slave byte on `o_receive`.
- `o_busy` brackets the whole transaction, so upstream FSMs can drop `i_valid` on the busy rising edge and advance on the falling edge.

## Interface
- `SYS_CLK_HZ`, default 100_000_000: system clock frequency.
- `I2C_HZ`, default 100_000: SCL frequency. Quarter-bit period is QTR = SYS_CLK_HZ/(4*I2C_HZ), which is 250 cycles at the defaults.
- `clk`  in  1  system clock. One clock domain; all logic is on the rising edge.
- `reset_p`  in  1  reset, synchronous and active-high.
- `i_valid`  in  1  transaction request; level-sampled in IDLE only.
- `i_addr`  in  7  slave address.
- `i_data`  in  8  write byte.
- `i_RW`  in  1  1 = read, 0 = write.
- `o_busy`  out  1  high from acceptance until STOP completes.
- `o_receive`  out  8  last byte read.
- `o_nack`  out  1  slave NACK seen in the last transaction.
- `scl`  out  1  I2C clock, push-pull, no clock-stretch support.
- `sda`  inout  1  I2C data, open-drain: drives 0 or `1'bz`, never 1.

## Operation
- States: IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_NACK, STOP.
- Each state is a whole number of bit periods. One bit period is 4 quarters q0..q3, each QTR cycles long, timed by a quarter counter and a bit counter.
- IDLE:
  - `scl`=1, `sda` released, `o_busy`=0.
  - If `i_valid`=1, latch `{i_addr,i_RW}` and `i_data`, clear `o_nack`, go to START.
  - `o_busy` goes to 1 on the next cycle.
- START (1 bit):
  - q0–q1: SDA=1, SCL=1.
  - q2: SDA=0, SCL=1.
  - q3: SDA=0, SCL=0.
- Data/ACK bit shape:
  - q0: SCL=0, SDA changes.
  - q1–q2: SCL=1.
  - q3: SCL=0.
  - Slave-driven bits are sampled on the first cycle of q2.
- ADDR: 8 bits, shifted MSB first, `{addr[6:0],RW}`.
- ADDR_ACK: SDA released and sampled.
- Then WRITE if RW=0, READ if RW=1.
- WRITE: 8 bits MSB first, followed by WRITE_ACK (SDA released and sampled).
- READ:
  - SDA released for 8 bits; bits shifted in MSB first.
  - READ_NACK: SDA released (NACK).
  - `o_receive` updates at the end of READ_NACK.
  - `o_receive` holds its value across write transactions.
- STOP (1 bit):
  - q0: SDA=0, SCL=0.
  - q1: SDA=0, SCL=1.
  - q2–q3: SDA released, SCL=1.
  - Then IDLE.
- Inputs are sampled only at acceptance. Changes to `i_addr`/`i_data`/`i_RW`/`i_valid` while busy are ignored.

## Timing
- Reset values: `scl`=1, `sda`=z, `o_busy`=0, `o_receive`=8'h00, `o_nack`=0, state=IDLE, counters=0.
- Acceptance to `o_busy` rise: 1 cycle.
- Full transaction: 20 bit periods, i.e. 80*QTR cycles of `o_busy`=1 (20000 at the defaults).
- `o_busy` falls on the cycle after STOP q3 ends.
- `o_receive` and `o_nack` are valid on the cycle `o_busy` falls.
- After `o_busy` falls, at least 1 IDLE cycle with `o_busy`=0 occurs before `i_valid` is sampled again.
- If `i_valid` is still high at that point, a new transaction starts.
- Reset mid-transaction:
  - Abort within that cycle: `scl`=1, `sda` released, `o_busy`=0, no STOP generated.
  - `o_receive` is reset to 0.

## Configuration
- `I2C_ACK_CHECK_EN` defined:
  - SDA=1 sampled in ADDR_ACK sets `o_nack`=1 and jumps directly to STOP, skipping the data byte. `o_busy` width is then 11*4*QTR cycles.
  - SDA=1 sampled in WRITE_ACK sets `o_nack`=1; STOP follows normally.
- `I2C_ACK_CHECK_EN` undefined:
  - ACK slots are not evaluated.
  - `o_nack` is tied to 0.
  - Every transaction runs the full 20 bit periods.

## Test plan
- **Write:** `i_addr`=7'h27, `i_RW`=0, `i_data`=8'hD9, slave ACKs.
  - SDA bytes decoded 8'h4E, ACK, 8'hD9, ACK, STOP.
  - `o_busy` high exactly 20000 cycles; `o_receive` stays 8'h00.
- **Read:** `i_RW`=1, slave model drives 8'hA5.
  - Address byte 8'h4F; master releases SDA for the 9th bit.
  - `o_receive`=8'hA5 on the cycle `o_busy` falls.
- **Address NACK** (`I2C_ACK_CHECK_EN` defined): no slave present.
  - `o_nack`=1; `o_busy` width 11000 cycles; no data bits on the bus.
  - Without the macro: width 20000 and `o_nack`=0.
- **Busy handshake:** hold `i_valid`=1 for 3 cycles then drop it, and change `i_data` mid-transaction.
  - Exactly one transaction runs, carrying the originally latched byte.
  - Holding `i_valid` high continuously produces back-to-back transactions separated by at least 1 cycle of `o_busy`=0.
- **Reset mid-ADDR:** assert `reset_p` during bit 3.
  - Next cycle: `scl`=1, `sda`=z, `o_busy`=0, `o_receive`=0.
  - A subsequent write completes normally.
